// File: rtl/calc_pkg.sv
// calc_pkg: FSM state encoding and debounce default shared by calc_ctrl and calc_debounce
package calc_pkg;
  typedef enum logic [2:0] {IDLE, LATCH, EXEC, WRITE, HOLD} state_e;
  localparam int DEBOUNCE_CYCLES_DEF = 4;
endpackage

// File: rtl/calc_debounce.sv
// calc_debounce: 2-flop synchronizer plus debouncer; ports clk, rst_n, raw_i -> registered level_o and one-cycle rise_o
module calc_debounce import calc_pkg::*; #(
  parameter int CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  output logic level_o,
  output logic rise_o
);
  localparam int CW = $clog2(CYCLES + 1);
  logic [1:0] sync_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic lvl_q, lvl_d, rise_q, done;
  assign done = (sync_q[1] != lvl_q) && (cnt_q == CW'(CYCLES - 1));
  always_comb begin
    cnt_d = (sync_q[1] == lvl_q || done) ? '0 : cnt_q + CW'(1);
    lvl_d = done ? sync_q[1] : lvl_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw_i};
      cnt_q  <= cnt_d;
      lvl_q  <= lvl_d;
      rise_q <= done & sync_q[1];
    end
  end
  assign level_o = lvl_q;
  assign rise_o  = rise_q;
endmodule

// File: rtl/calc_ctrl.sv
// calc_ctrl: button-driven calculator sequencer; syncs buttons/switches, latches op/operand, strobes acc_we/acc_clr, counts writes
module calc_ctrl import calc_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             btnc,
  input  logic             btnl,
  input  logic             btnr,
  input  logic             btnu,
  input  logic             btnd,
  input  logic [15:0]      sw,
  output logic [2:0]       op_btn,
  output logic [15:0]      operand,
  output logic             acc_we,
  output logic             acc_clr,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);
  logic [18:0] s1_q, s2_q;
  logic u_lvl, u_rise, d_lvl, d_rise;
  logic [2:0] op_btn_q;
  logic [15:0] operand_q;
  logic acc_we_q, acc_clr_q, busy_q;
  logic [CNT_W-1:0] op_count_q;
  state_e state_q, state_d;
  calc_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_u (.clk(clk), .rst_n(rst_n), .raw_i(btnu), .level_o(u_lvl), .rise_o(u_rise));
  calc_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db_d (.clk(clk), .rst_n(rst_n), .raw_i(btnd), .level_o(d_lvl), .rise_o(d_rise));
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = d_rise ? LATCH : IDLE;
      LATCH:   state_d = EXEC;
      EXEC:    state_d = WRITE;
      WRITE:   state_d = HOLD;
      HOLD:    state_d = d_lvl ? HOLD : IDLE;
      default: state_d = IDLE;
    endcase
    if (u_rise) state_d = HOLD;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= '0;
      s2_q       <= '0;
      state_q    <= IDLE;
      op_btn_q   <= '0;
      operand_q  <= '0;
      acc_we_q   <= 1'b0;
      acc_clr_q  <= 1'b0;
      busy_q     <= 1'b0;
      op_count_q <= '0;
    end else begin
      s1_q      <= {btnc, btnl, btnr, sw};
      s2_q      <= s1_q;
      state_q   <= state_d;
      if (state_q == LATCH && !u_rise) begin
        op_btn_q  <= s2_q[18:16];
        operand_q <= s2_q[15:0];
      end
      acc_we_q  <= state_d == WRITE;
      acc_clr_q <= u_rise;
      busy_q    <= state_d != IDLE;
      if (state_d == WRITE) op_count_q <= op_count_q + CNT_W'(1);
    end
  end
  a_rise_has_level: assert property (@(posedge clk) disable iff (!rst_n) !u_rise || u_lvl);
  assign op_btn   = op_btn_q;
  assign operand  = operand_q;
  assign acc_we   = acc_we_q;
  assign acc_clr  = acc_clr_q;
  assign busy     = busy_q;
  assign op_count = op_count_q;
endmodule

// File: tb/tb_calc_ctrl.sv
// tb_calc_ctrl: randomized and directed self-checking bench for calc_ctrl against a window-rule reference model
module tb_calc_ctrl;
  localparam int N = 4;
  localparam int CW = 8;
  logic clk = 1'b0, rst_n = 1'b1;
  logic btnc = 1'b0, btnl = 1'b0, btnr = 1'b0, btnu = 1'b0, btnd = 1'b0;
  logic [15:0] sw = '0;
  logic [2:0] op_btn;
  logic [15:0] operand;
  logic acc_we, acc_clr, busy;
  logic [CW-1:0] op_count;
  calc_ctrl #(.DEBOUNCE_CYCLES(N), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .btnc(btnc), .btnl(btnl), .btnr(btnr), .btnu(btnu), .btnd(btnd), .sw(sw),
    .op_btn(op_btn), .operand(operand), .acc_we(acc_we), .acc_clr(acc_clr), .busy(busy), .op_count(op_count)
  );
  always #5 clk = ~clk;
  int n_vec = 0, n_err = 0;
  bit [18:0] hx[$];
  bit hu[$], hd[$];
  bit du, dd, ru, rd, hold, e_we, e_clr, e_busy;
  int age;
  logic [2:0] e_op;
  logic [15:0] e_opnd;
  logic [CW-1:0] e_cnt;
  int we_seen, clr_seen, cyc, we_at;
  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit next_level(bit q[$], bit cur);
    int k = q.size() - 1;
    for (int i = 0; i < N; i++) begin
      int j = k - i - 2;
      bit v = (j >= 0) ? q[j] : 1'b0;
      if (v == cur) return cur;
    end
    return !cur;
  endfunction
  task automatic model_edge();
    bit nu, nd;
    bit [18:0] s;
    hx.push_back({btnc, btnl, btnr, sw});
    hu.push_back(btnu);
    hd.push_back(btnd);
    s = (hx.size() >= 3) ? hx[hx.size() - 3] : '0;
    e_clr = ru;
    e_we = 1'b0;
    if (ru) begin age = 0; hold = 1'b1; end
    else if (age == 1) begin e_op = s[18:16]; e_opnd = s[15:0]; age = 2; end
    else if (age == 2) begin e_we = 1'b1; e_cnt = e_cnt + 1'b1; age = 3; end
    else if (age == 3) begin age = 0; hold = 1'b1; end
    else if (hold) hold = dd;
    else if (rd) age = 1;
    e_busy = (age != 0) || hold;
    nu = next_level(hu, du);
    nd = next_level(hd, dd);
    ru = nu & !du;
    rd = nd & !dd;
    du = nu;
    dd = nd;
  endtask
  task automatic clr_model();
    hx.delete(); hu.delete(); hd.delete();
    du = 0; dd = 0; ru = 0; rd = 0; hold = 0; age = 0;
    e_we = 0; e_clr = 0; e_busy = 0; e_op = '0; e_opnd = '0; e_cnt = '0;
  endtask
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    cyc++;
    if (acc_we) begin we_seen++; we_at = cyc; end
    if (acc_clr) clr_seen++;
    check("acc_we", acc_we, e_we);
    check("acc_clr", acc_clr, e_clr);
    check("busy", busy, e_busy);
    check("op_count", op_count, e_cnt);
    check("op_btn", op_btn, e_op);
    check("operand", operand, e_opnd);
  endtask
  task automatic run(int n);
    repeat (n) step();
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_acc_we", acc_we, 0);
    check("rst_acc_clr", acc_clr, 0);
    check("rst_busy", busy, 0);
    check("rst_op_count", op_count, 0);
    check("rst_op_btn", op_btn, 0);
    check("rst_operand", operand, 0);
    clr_model();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    bit found;
    #2;
    do_reset();
    run(3);
    sw = 16'h0005; btnl = 1'b1;
    run(4);
    we_seen = 0; cyc = 0; we_at = -1;
    btnd = 1'b1; run(20); btnd = 1'b0; run(12);
    check("exec_we_once", we_seen, 1);
    check("exec_latency", we_at, 9);
    check("exec_count", op_count, 1);
    check("exec_operand", operand, 16'h0005);
    check("exec_op", op_btn, 3'b010);
    we_seen = 0;
    for (int i = 0; i < 6; i++) begin btnd = ~btnd; run(2); end
    btnd = 1'b0; run(12);
    check("bounce_we", we_seen, 0);
    we_seen = 0; clr_seen = 0;
    btnu = 1'b1; btnd = 1'b1; run(12); btnu = 1'b0; btnd = 1'b0; run(12);
    check("prio_we", we_seen, 0);
    check("prio_clr", clr_seen, 1);
    sw = 16'h1234; btnc = 1'b1; btnl = 1'b0;
    we_seen = 0; clr_seen = 0;
    btnd = 1'b1; run(2); btnu = 1'b1; run(14); btnd = 1'b0; btnu = 1'b0; run(12);
    check("abort_we", we_seen, 0);
    check("abort_clr", clr_seen, 1);
    check("abort_count", op_count, 1);
    do_reset();
    run(3);
    we_seen = 0;
    for (int i = 0; i < 256; i++) begin btnd = 1'b1; run(8); btnd = 1'b0; run(10); end
    check("wrap_writes", we_seen, 256);
    check("wrap_count", op_count, 0);
    btnd = 1'b1; found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin step(); found = e_we; end
    check("reach_write", found, 1);
    do_reset();
    we_seen = 0;
    run(20); btnd = 1'b0; run(12);
    check("held_through_reset", we_seen, 1);
    repeat (150) begin
      btnu = ($urandom_range(0, 5) == 0);
      btnd = 1'($urandom_range(0, 1));
      {btnc, btnl, btnr} = 3'($urandom);
      sw = 16'($urandom);
      run($urandom_range(1, 12));
      if ($urandom_range(0, 29) == 0) do_reset();
    end
    btnu = 1'b0; btnd = 1'b0; run(15);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1);
  end
endmodule
